watch_set_ctrl: RTL

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_pkg.sv | 32 +++
 rtl/btn_edge.sv | 32 +++
 rtl/watch_set_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared encodings for the watch set-mode controller: mode values,
// adjust direction and the bit position of each button in the button vector.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  // Btn_R walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      RUN:      n = SET_HOUR;
      SET_HOUR: n = SET_MIN;
      SET_MIN:  n = SET_SEC;
      default:  n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers one debounced button level and flags its rising edge.
// A button already held when reset releases must be seen low once before it can press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  logic level_reg;
  logic prev_reg;
  logic armed_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 1'b0;
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      level_reg <= btn;
      prev_reg  <= level_reg;
      if (!btn) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign level = level_reg & armed_reg;
  assign press = level_reg & ~prev_reg & armed_reg;

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch set-mode controller: mode FSM, field adjust pulses, tick/msec control, blink gate.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on Btn_U / Btn_D.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int BLINK_HALF   = 50_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Btn_L,
  input  logic       Btn_R,
  input  logic       Btn_U,
  input  logic       Btn_D,
  output logic       o_run_hour,
  output logic       o_run_min,
  output logic       o_run_sec,
  output logic       o_dir,
  output logic       o_tick_en,
  output logic       o_msec_clr,
  output logic [1:0] o_mode,
  output logic       o_blink
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  if (BLINK_HALF < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("watch_set_ctrl: need BLINK_HALF >= 1 and 1 <= REPEAT_RATE <= REPEAT_DELAY");
  end

  logic [3:0] btn_raw;
  logic [3:0] level;
  logic [3:0] press;

  assign btn_raw = {Btn_D, Btn_U, Btn_R, Btn_L};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_raw[gi]),
        .level (level[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  mode_t              state;
  mode_t              state_next;
  logic               mode_change;
  logic               in_set;
  logic               adj_press;
  logic               rep_fire;
  logic               rep_dir;
  logic               fire;
  logic               fire_dir;
  logic [BLINK_W-1:0] blink_cnt;

  // Btn_L has priority over Btn_R; in RUN it simply swallows a coincident R.
  always_comb begin
    state_next = state;
    if (press[BTN_L]) begin
      if (state != RUN) begin
        state_next = RUN;
      end
    end else if (press[BTN_R]) begin
      state_next = next_mode(state);
    end
  end

  assign mode_change = (state_next != state);
  assign in_set      = (state != RUN);
  assign adj_press   = in_set && !mode_change && (press[BTN_U] ^ press[BTN_D]);
  assign fire        = adj_press || rep_fire;
  assign fire_dir    = adj_press ? (press[BTN_D] ? DIR_DN : DIR_UP) : rep_dir;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

  logic              hold_active;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_ok;

  // Counting only follows an accepted press, so a button carried through reset never repeats.
  assign hold_ok  = hold_active && in_set && !mode_change && (level[BTN_U] ^ level[BTN_D]);
  assign rep_fire = hold_ok && (hold_cnt == DELAY_LAST);
  assign rep_dir  = level[BTN_D] ? DIR_DN : DIR_UP;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_active <= 1'b0;
      hold_cnt    <= '0;
    end else if (adj_press) begin
      hold_active <= 1'b1;
      hold_cnt    <= '0;
    end else if (!hold_ok) begin
      hold_active <= 1'b0;
      hold_cnt    <= '0;
    end else if (rep_fire) begin
      hold_cnt    <= RATE_RELOAD;
    end else begin
      hold_cnt    <= hold_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_dir  = DIR_UP;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      o_tick_en  <= 1'b1;
      o_msec_clr <= 1'b0;
      o_run_hour <= 1'b0;
      o_run_min  <= 1'b0;
      o_run_sec  <= 1'b0;
      o_dir      <= DIR_UP;
      o_blink    <= 1'b1;
      blink_cnt  <= '0;
    end else begin
      state      <= state_next;
      o_tick_en  <= (state_next == RUN);
      o_msec_clr <= in_set && (state_next == RUN);
      o_run_hour <= fire && (state == SET_HOUR);
      o_run_min  <= fire && (state == SET_MIN);
      o_run_sec  <= fire && (state == SET_SEC);
      if (fire) begin
        o_dir <= fire_dir;
      end
      // Each new mode restarts the blink phase with the field visible.
      if (mode_change || state_next == RUN) begin
        blink_cnt <= '0;
        o_blink   <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        o_blink   <= ~o_blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign o_mode = state;

endmodule
